// File: rtl/async_fifo_write_ctrl_pkg.sv
// Shared FIFO pointer helpers, used by both the write-side and the read-side
// controllers of the clock-crossing FIFO.
//   PTR_WIDTH(aw)        pointer width: one wrap bit above the address bits
//   DEPTH(aw)            number of FIFO entries
//   fifoOccupancy(w,r,a) (w - r) modulo 2^(a+1), zero-extended to 32 bits
package fifo_pkg;

    function automatic int unsigned PTR_WIDTH(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned DEPTH(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic logic [31:0] fifoOccupancy(input logic [31:0] wr,
                                                  input logic [31:0] rd,
                                                  input int unsigned addr_width);
        logic [31:0] mask;
        mask = (32'd1 << (addr_width + 1)) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/async_fifo_write_ctrl_if.sv
// Write-side bus of the clock-crossing FIFO.
//   push           write request
//   ramWriteEnable RAM write strobe
//   ramWriteAddr   RAM write address
//   wrPtr          binary write pointer towards the Gray-code CDC pipe
//   rdPtrSynced    binary read pointer coming back from the CDC pipe
//   usedw          registered occupancy
//   full           backpressure (combinational from registers)
//   almostFull     registered early-warning flag
//   overflowError  sticky: push attempted while full
//   pointerError   sticky: read pointer appeared ahead of write pointer
// master = upstream writer / read-side pipe, slave = write controller.
interface async_fifo_write_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  push;
    logic                  ramWriteEnable;
    logic [ADDR_WIDTH-1:0] ramWriteAddr;
    logic [ADDR_WIDTH:0]   wrPtr;
    logic [ADDR_WIDTH:0]   rdPtrSynced;
    logic [ADDR_WIDTH:0]   usedw;
    logic                  full;
    logic                  almostFull;
    logic                  overflowError;
    logic                  pointerError;

    modport master (
        output push, rdPtrSynced,
        input  ramWriteEnable, ramWriteAddr, wrPtr, usedw,
               full, almostFull, overflowError, pointerError
    );

    modport slave (
        input  push, rdPtrSynced,
        output ramWriteEnable, ramWriteAddr, wrPtr, usedw,
               full, almostFull, overflowError, pointerError
    );
endinterface

// File: rtl/fifo_occupancy_flags.sv
// Pure combinational occupancy and level compare for one pointer pair.
//   wr_ptr, rd_ptr  binary pointers (ADDR_WIDTH+1 bits)
//   occupancy       wr_ptr - rd_ptr modulo pointer range
//   full            occupancy == DEPTH
//   almost_full     free entries <= ALMOST_FULL_MARGIN (or pointers corrupt)
//   pointer_error   occupancy > DEPTH, i.e. read side appears ahead
module fifo_occupancy_flags
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = 4,
    parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
    input  logic [PTR_WIDTH(ADDR_WIDTH)-1:0] wr_ptr,
    input  logic [PTR_WIDTH(ADDR_WIDTH)-1:0] rd_ptr,
    output logic [PTR_WIDTH(ADDR_WIDTH)-1:0] occupancy,
    output logic                             full,
    output logic                             almost_full,
    output logic                             pointer_error
);
    localparam int unsigned PW = PTR_WIDTH(ADDR_WIDTH);
    localparam int unsigned D  = DEPTH(ADDR_WIDTH);

    logic [31:0] diff;

    always_comb begin
        diff          = fifoOccupancy(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
        occupancy     = diff[PW-1:0];
        full          = (diff == D);
        pointer_error = (diff > D);
        // An impossible occupancy counts as "no room left" so the free-count
        // subtraction below never sees a wrapped value.
        almost_full   = pointer_error || ((D - diff) <= ALMOST_FULL_MARGIN);
    end
endmodule

// File: rtl/async_fifo_write_ctrl.sv
// Write-side pointer/flag controller of the clock-crossing FIFO.
//   clk      write-domain clock
//   aresetn  asynchronous active-low reset (deassertion synchronised outside)
//   bus      slave side of async_fifo_write_ctrl_if (push in, RAM strobe,
//            pointer, occupancy and flags out)
// A write is accepted when push && !full; wrPtr advances on the next edge.
module async_fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = 4,
    parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    async_fifo_write_ctrl_if.slave  bus
);
    localparam int unsigned PW = PTR_WIDTH(ADDR_WIDTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] usedw_q;
    logic          almost_full_q;
    logic          overflow_q;
    logic          pointer_error_q;
    logic          accept;
    logic          full;

    logic [PW-1:0] cur_occ;
    logic          cur_full;
    logic          cur_af;
    logic          cur_perr;
    logic [PW-1:0] nxt_occ;
    logic          nxt_full;
    logic          nxt_af;
    logic          nxt_perr;
    logic          unused_flags;

    // Current pointers: drive full and the pointer-error detector.
    fifo_occupancy_flags #(
        .ADDR_WIDTH         (ADDR_WIDTH),
        .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
    ) u_cur_flags (
        .wr_ptr        (wr_ptr_q),
        .rd_ptr        (bus.rdPtrSynced),
        .occupancy     (cur_occ),
        .full          (cur_full),
        .almost_full   (cur_af),
        .pointer_error (cur_perr)
    );

    // Post-increment pointer: next-state values of usedw / almostFull.
    fifo_occupancy_flags #(
        .ADDR_WIDTH         (ADDR_WIDTH),
        .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
    ) u_nxt_flags (
        .wr_ptr        (wr_ptr_next),
        .rd_ptr        (bus.rdPtrSynced),
        .occupancy     (nxt_occ),
        .full          (nxt_full),
        .almost_full   (nxt_af),
        .pointer_error (nxt_perr)
    );

    assign unused_flags = ^{cur_occ, cur_af, nxt_full, nxt_perr};

    // full depends only on registers, never on push. An out-of-range
    // difference or a latched pointer error also blocks writes.
    assign full        = cur_full || cur_perr || pointer_error_q;
    assign accept      = bus.push && !full;
    assign wr_ptr_next = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q        <= '0;
            usedw_q         <= '0;
            almost_full_q   <= 1'b0;
            overflow_q      <= 1'b0;
            pointer_error_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_next;
            usedw_q       <= nxt_occ;
            almost_full_q <= nxt_af;
            if (bus.push && full) begin
                overflow_q <= 1'b1;
            end
            if (cur_perr) begin
                pointer_error_q <= 1'b1;
            end
        end
    end

    assign bus.ramWriteEnable = accept;
    assign bus.ramWriteAddr   = wr_ptr_q[ADDR_WIDTH-1:0];
    assign bus.wrPtr          = wr_ptr_q;
    assign bus.usedw          = usedw_q;
    assign bus.full           = full;
    assign bus.almostFull     = almost_full_q;
    assign bus.overflowError  = overflow_q;
    assign bus.pointerError   = pointer_error_q;
endmodule

// File: tb/tb_async_fifo_write_ctrl.sv
// Scoreboard bench for async_fifo_write_ctrl (ADDR_WIDTH=4, margin 4).
// Each cycle the expected outputs are derived from a small reference model,
// queued when stimulus is driven, and popped at the following negedge.
module tb_async_fifo_write_ctrl;

    logic clk;
    logic aresetn;

    async_fifo_write_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    async_fifo_write_ctrl #(
        .ADDR_WIDTH         (4),
        .ALMOST_FULL_MARGIN (4)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic       full;
        logic [4:0] wr;
        logic [4:0] usedw;
        logic       af;
        logic       ovf;
        logic       perr;
    } exp_t;

    exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    logic [4:0] m_wr;
    logic [4:0] m_usedw;
    logic       m_af;
    logic       m_ovf;
    logic       m_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr    = '0;
        m_usedw = '0;
        m_af    = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle and compares at the negedge.
    task automatic cycle(input logic p, input logic [4:0] rd);
        exp_t       e;
        exp_t       o;
        logic [4:0] diff;
        logic [4:0] nwr;
        bus.push        = p;
        bus.rdPtrSynced = rd;
        diff    = m_wr - rd;
        e.full  = (diff >= 5'd16) || m_perr;
        e.we    = p && !e.full;
        e.addr  = m_wr[3:0];
        e.wr    = m_wr;
        e.usedw = m_usedw;
        e.af    = m_af;
        e.ovf   = m_ovf;
        e.perr  = m_perr;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check("ramWriteEnable", 32'(bus.ramWriteEnable), 32'(o.we));
        check("ramWriteAddr",   32'(bus.ramWriteAddr),   32'(o.addr));
        check("full",           32'(bus.full),           32'(o.full));
        check("wrPtr",          32'(bus.wrPtr),          32'(o.wr));
        check("usedw",          32'(bus.usedw),          32'(o.usedw));
        check("almostFull",     32'(bus.almostFull),     32'(o.af));
        check("overflowError",  32'(bus.overflowError),  32'(o.ovf));
        check("pointerError",   32'(bus.pointerError),   32'(o.perr));
        nwr     = e.we ? m_wr + 5'd1 : m_wr;
        m_usedw = nwr - rd;
        m_af    = (m_usedw > 5'd16) || ((5'd16 - m_usedw) <= 5'd4);
        m_ovf   = m_ovf || (p && e.full);
        m_perr  = m_perr || (diff > 5'd16);
        m_wr    = nwr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn         = 1'b0;
        bus.push        = 1'b0;
        bus.rdPtrSynced = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        // reset and idle
        do_reset();
        cycle(1'b0, 5'd0);
        cycle(1'b0, 5'd0);

        // fill: 16 accepted pushes, then rejected pushes while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 5'd0);
        check("fill_wrPtr",  32'(bus.wrPtr), 32'd16);
        check("fill_full",   32'(bus.full),  32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0);
        cycle(1'b0, 5'd0);
        check("ovf_sticky",  32'(bus.overflowError), 32'd1);

        // pointer wrap: bring wrPtr to 30 with rdPtrSynced 28
        do_reset();
        for (int i = 0; i < 14; i++) cycle(1'b1, 5'd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 5'd14);
        cycle(1'b0, 5'd28);
        cycle(1'b1, 5'd28);
        cycle(1'b1, 5'd28);
        cycle(1'b0, 5'd28);
        check("wrap_wrPtr", 32'(bus.wrPtr), 32'd0);
        check("wrap_usedw", 32'(bus.usedw), 32'd4);

        // read pointer ahead of write pointer
        do_reset();
        cycle(1'b1, 5'd0);
        cycle(1'b1, 5'd0);
        cycle(1'b0, 5'd5);
        cycle(1'b1, 5'd5);
        cycle(1'b1, 5'd2);
        cycle(1'b0, 5'd2);

        // asynchronous reset mid-burst at wrPtr=9
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 5'd0);
        bus.push = 1'b1;
        #2;
        bus.push = 1'b0;
        aresetn  = 1'b0;
        #1;
        check("arst_wrPtr",          32'(bus.wrPtr),          32'd0);
        check("arst_usedw",          32'(bus.usedw),          32'd0);
        check("arst_ramWriteAddr",   32'(bus.ramWriteAddr),   32'd0);
        check("arst_ramWriteEnable", 32'(bus.ramWriteEnable), 32'd0);
        check("arst_full",           32'(bus.full),           32'd0);
        check("arst_almostFull",     32'(bus.almostFull),     32'd0);
        check("arst_overflowError",  32'(bus.overflowError),  32'd0);
        check("arst_pointerError",   32'(bus.pointerError),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        cycle(1'b1, 5'd0);
        cycle(1'b1, 5'd0);
        cycle(1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
